// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: memory-side request/response bus of the data-memory access unit
interface dmem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: RV32I load/store sequencer with alignment check; DMEM_TIMEOUT_EN adds a ready timeout
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_en,
    input  logic               st_en,
    input  logic [2:0]         func3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               stall,
    output logic               done,
    output logic               err,
    output logic [31:0]        ld_data,
    dmem_access_unit_if.master mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state;
    logic        is_ld;
    logic [1:0]  off;
    logic        is_h;
    logic        is_w;
    logic        misaligned;
    logic [3:0]  strb;
    logic [31:0] wdat;
`ifdef DMEM_TIMEOUT_EN
    logic [15:0] cnt;
`endif

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

    // decode width class, alignment and store lane placement of the incoming request
    always_comb begin
        is_h       = func3 == 3'b001 || func3 == 3'b101;
        is_w       = func3 == 3'b010;
        misaligned = (is_h && addr[0]) || (is_w && addr[1:0] != 2'b00);
        strb       = ld_en ? 4'b0000 : is_w ? 4'b1111 : is_h ? 4'b0011 << addr[1:0] : 4'b0001 << addr[1:0];
        wdat       = is_w ? wdata : is_h ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    end

    // freeze the core while a request waits for acceptance or the bus access is in flight
    assign stall = rst_n && ((state == IDLE && (ld_en || st_en)) || state == ACCESS);

    // request sequencer: latch on acceptance, run the bus access, pulse done for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            is_ld         <= 1'b0;
            off           <= 2'b00;
            done          <= 1'b0;
            err           <= 1'b0;
            ld_data       <= 32'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wstrb <= 4'b0000;
            mem.mem_wdata <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
            cnt           <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (ld_en || st_en) begin
                    is_ld        <= ld_en;
                    off          <= addr[1:0];
                    mem.mem_addr <= {addr[31:2], 2'b00};
                    if (misaligned) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state         <= ACCESS;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= !ld_en;
                        mem.mem_wstrb <= strb;
                        mem.mem_wdata <= wdat;
`ifdef DMEM_TIMEOUT_EN
                        cnt           <= 16'd0;
`endif
                    end
                end
                ACCESS: begin
                    if (mem.mem_ready) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_wstrb <= 4'b0000;
                        if (is_ld)
                            ld_data <= mem.mem_rdata >> {off, 3'b000};
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        err           <= 1'b1;
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_wstrb <= 4'b0000;
                    end else
                        cnt <= cnt + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
